// File: rtl/decode_issue_ctrl.sv
// Single-issue RV32I decode/issue controller with register scoreboard.
// Optional perf counters when ISSUE_PERF_CNT_EN is defined.

module riscv_decoder (
  input  logic [31:0] instr,
  output logic [2:0]  fmt,
  output logic [6:0]  op,
  output logic [2:0]  funct3,
  output logic [6:0]  funct7,
  output logic [4:0]  rd,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [31:0] imm
);
  localparam logic [2:0] F_R = 3'd0;
  localparam logic [2:0] F_I = 3'd1;
  localparam logic [2:0] F_S = 3'd2;
  localparam logic [2:0] F_B = 3'd3;
  localparam logic [2:0] F_U = 3'd4;
  localparam logic [2:0] F_J = 3'd5;
  localparam logic [2:0] F_E = 3'd7;

  assign op     = instr[6:0];
  assign rd     = instr[11:7];
  assign funct3 = instr[14:12];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign funct7 = instr[31:25];

  // format from major opcode
  always_comb begin
    fmt = F_E;
    case (instr[6:0])
      7'b0110011: fmt = F_R;
      7'b0010011,
      7'b0000011,
      7'b1100111,
      7'b1110011,
      7'b0001111: fmt = F_I;
      7'b0100011: fmt = F_S;
      7'b1100011: fmt = F_B;
      7'b0110111,
      7'b0010111: fmt = F_U;
      7'b1101111: fmt = F_J;
      default:    fmt = F_E;
    endcase
  end

  // immediate assembly per format
  always_comb begin
    imm = '0;
    unique case (1'b1)
      (fmt == F_I):
        imm = {{20{instr[31]}}, instr[31:20]};
      (fmt == F_S):
        imm = {{20{instr[31]}}, instr[31:25],
               instr[11:7]};
      (fmt == F_B):
        imm = {{19{instr[31]}}, instr[31],
               instr[7], instr[30:25],
               instr[11:8], 1'b0};
      (fmt == F_U):
        imm = {instr[31:12], 12'b0};
      (fmt == F_J):
        imm = {{11{instr[31]}}, instr[31],
               instr[19:12], instr[20],
               instr[30:21], 1'b0};
      default: imm = '0;
    endcase
  end
endmodule

module decode_issue_ctrl #(
  parameter int MAX_INFLIGHT = 4,
  parameter int CNT_W = $clog2(MAX_INFLIGHT + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             instr_valid_i,
  output logic             instr_ready_o,
  input  logic [31:0]      instr_i,
  output logic             issue_valid_o,
  input  logic             issue_ready_i,
  output logic [2:0]       issue_format_o,
  output logic [6:0]       issue_op_o,
  output logic [2:0]       issue_funct3_o,
  output logic [6:0]       issue_funct7_o,
  output logic [4:0]       issue_rd_o,
  output logic [4:0]       issue_rs1_o,
  output logic [4:0]       issue_rs2_o,
  output logic [31:0]      issue_imm_o,
  input  logic             wb_valid_i,
  input  logic [4:0]       wb_rd_i,
  input  logic             flush_i,
  output logic             illegal_o,
  output logic [31:0]      busy_o,
  output logic [CNT_W-1:0] inflight_o
`ifdef ISSUE_PERF_CNT_EN
  ,
  output logic [31:0]      issued_cnt_o,
  output logic [31:0]      stall_cnt_o,
  output logic [31:0]      illegal_cnt_o
`endif
);
  localparam logic [2:0] F_R = 3'd0;
  localparam logic [2:0] F_I = 3'd1;
  localparam logic [2:0] F_S = 3'd2;
  localparam logic [2:0] F_B = 3'd3;
  localparam logic [2:0] F_U = 3'd4;
  localparam logic [2:0] F_J = 3'd5;
  localparam logic [2:0] F_E = 3'd7;
  localparam logic [CNT_W-1:0] MAX_C =
    CNT_W'(MAX_INFLIGHT);

  typedef enum logic {EMPTY, HOLD} state_t;

  state_t state, state_n;

  logic [2:0]  d_fmt, h_fmt;
  logic [6:0]  d_op, h_op;
  logic [2:0]  d_f3, h_f3;
  logic [6:0]  d_f7, h_f7;
  logic [4:0]  d_rd, h_rd;
  logic [4:0]  d_rs1, h_rs1;
  logic [4:0]  d_rs2, h_rs2;
  logic [31:0] d_imm, h_imm;

  logic [31:0] busy, busy_n;
  logic [CNT_W-1:0] inflight;
  logic use_rs1, use_rs2, use_rd;
  logic writes, full, hazard;
  logic valid, fire, ready;
  logic accept, dec_err, illegal;

  riscv_decoder u_dec (
    .instr  (instr_i),
    .fmt    (d_fmt),
    .op     (d_op),
    .funct3 (d_f3),
    .funct7 (d_f7),
    .rd     (d_rd),
    .rs1    (d_rs1),
    .rs2    (d_rs2),
    .imm    (d_imm)
  );

  function automatic logic [CNT_W-1:0] popcnt(
    input logic [31:0] v
  );
    logic [CNT_W-1:0] c;
    c = '0;
    for (int k = 1; k < 32; k++)
      c = c + CNT_W'(v[k]);
    return c;
  endfunction

  // register usage of the held instruction
  always_comb begin
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    use_rd  = 1'b0;
    unique case (1'b1)
      (h_fmt == F_R): begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        use_rd  = 1'b1;
      end
      (h_fmt == F_I): begin
        use_rs1 = 1'b1;
        use_rd  = 1'b1;
      end
      (h_fmt == F_S),
      (h_fmt == F_B): begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      (h_fmt == F_U),
      (h_fmt == F_J): use_rd = 1'b1;
      default: ;
    endcase
  end

  assign inflight = popcnt(busy);
  assign full     = (inflight == MAX_C);
  assign writes   = use_rd & (h_rd != 5'd0);
  assign hazard   = (use_rs1 & busy[h_rs1])
                  | (use_rs2 & busy[h_rs2])
                  | (writes & (busy[h_rd] | full));
  assign valid    = (state == HOLD) & ~hazard
                  & ~flush_i;
  assign fire     = valid & issue_ready_i;
  assign ready    = ~flush_i
                  & ((state == EMPTY) | fire);
  assign accept   = instr_valid_i & ready;
  assign dec_err  = (d_fmt == F_E);

  // state register
  always_ff @(posedge clk_i) begin
    if (!rst_ni) state <= EMPTY;
    else         state <= state_n;
  end

  // next state: flush wins, illegal accepts drop
  always_comb begin
    state_n = state;
    if (flush_i)     state_n = EMPTY;
    else if (accept) state_n = dec_err ? EMPTY : HOLD;
    else if (fire)   state_n = EMPTY;
  end

  // outputs; data forced to 0 while not valid
  always_comb begin
    instr_ready_o  = ready;
    issue_valid_o  = valid;
    issue_format_o = valid ? h_fmt : '0;
    issue_op_o     = valid ? h_op  : '0;
    issue_funct3_o = valid ? h_f3  : '0;
    issue_funct7_o = valid ? h_f7  : '0;
    issue_rd_o     = valid ? h_rd  : '0;
    issue_rs1_o    = valid ? h_rs1 : '0;
    issue_rs2_o    = valid ? h_rs2 : '0;
    issue_imm_o    = valid ? h_imm : '0;
    illegal_o      = illegal;
    busy_o         = busy;
    inflight_o     = inflight;
  end

  // decode register loads on legal accept
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      h_fmt <= '0;
      h_op  <= '0;
      h_f3  <= '0;
      h_f7  <= '0;
      h_rd  <= '0;
      h_rs1 <= '0;
      h_rs2 <= '0;
      h_imm <= '0;
    end else if (accept & ~dec_err) begin
      h_fmt <= d_fmt;
      h_op  <= d_op;
      h_f3  <= d_f3;
      h_f7  <= d_f7;
      h_rd  <= d_rd;
      h_rs1 <= d_rs1;
      h_rs2 <= d_rs2;
      h_imm <= d_imm;
    end
  end

  // one-cycle pulse for a dropped instruction
  always_ff @(posedge clk_i) begin
    if (!rst_ni) illegal <= 1'b0;
    else         illegal <= accept & dec_err;
  end

  // scoreboard: clear on writeback, set on issue
  always_comb begin
    busy_n = busy;
    if (wb_valid_i)     busy_n[wb_rd_i] = 1'b0;
    if (fire & writes)  busy_n[h_rd]    = 1'b1;
    busy_n[0] = 1'b0;
  end

  // scoreboard register
  always_ff @(posedge clk_i) begin
    if (!rst_ni) busy <= '0;
    else         busy <= busy_n;
  end

`ifdef ISSUE_PERF_CNT_EN
  logic stall;
  assign stall = (state == HOLD) & hazard & ~flush_i;

  // saturating performance counters
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      issued_cnt_o  <= '0;
      stall_cnt_o   <= '0;
      illegal_cnt_o <= '0;
    end else begin
      if (fire && issued_cnt_o != '1)
        issued_cnt_o <= issued_cnt_o + 32'd1;
      if (stall && stall_cnt_o != '1)
        stall_cnt_o <= stall_cnt_o + 32'd1;
      if (illegal && illegal_cnt_o != '1)
        illegal_cnt_o <= illegal_cnt_o + 32'd1;
    end
  end
`endif
endmodule
